// File: rtl/sirv_tcm_ram_bank.sv
// Single-port TCM bank: inferred storage, byte-masked writes, in-order valid/ready responses.
// Define SIRV_TCM_INIT_CLEAR_EN to zero-fill the whole array after every reset before accepting commands.
module sirv_tcm_ram_bank #(
    parameter int DP      = 512,
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int MW      = DW / 8,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          init_done
);

    localparam int IW = (DP > 1) ? $clog2(DP) : 1;

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q;
    logic            initDone_q;
    logic            initWe;
    logic [IW-1:0]   initIdx;

    logic            accept;
    logic            addrErr;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   rdNext;

    logic            rspValid_q;
    logic [DW-1:0]   rspRdata_q;
    logic            rspErr_q;
    logic            outAdv;

    logic [DW-1:0]   mem_q [DP];

    assign accept  = cmd_valid & cmd_ready;
    assign addrErr = ({1'b0, cmd_addr} >= (AW + 1)'(DP));
    assign idx     = cmd_addr[IW-1:0];
    assign outAdv  = ~rspValid_q | rsp_ready;

`ifdef SIRV_TCM_INIT_CLEAR_EN
    localparam int CW = $clog2(DP + 1);

    logic [CW-1:0] initCnt_q;

    // The counter walks one past the last word so RUN starts the cycle after the final clear write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            initCnt_q  <= '0;
            initDone_q <= 1'b0;
        end else if (state_q == INIT) begin
            if (initCnt_q == CW'(DP)) begin
                state_q    <= RUN;
                initDone_q <= 1'b1;
            end else begin
                initCnt_q <= initCnt_q + 1'b1;
            end
        end
    end

    assign initWe  = (state_q == INIT) && (initCnt_q < CW'(DP));
    assign initIdx = initCnt_q[IW-1:0];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= RUN;
            initDone_q <= 1'b1;
        end
    end

    assign initWe  = 1'b0;
    assign initIdx = '0;
`endif

    // Storage has no reset; out-of-range writes never reach it.
    always_ff @(posedge clk) begin
        if (initWe) begin
            mem_q[initIdx] <= '0;
        end else if (accept && !cmd_read && !addrErr) begin
            for (int i = 0; i < MW; i++) begin
                if (cmd_wmask[i]) begin
                    mem_q[idx][i*8 +: 8] <= cmd_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdNext = (cmd_read && !addrErr) ? mem_q[idx] : '0;

    if (OUT_REG == 0) begin : gDirect
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rspValid_q <= 1'b0;
                rspRdata_q <= '0;
                rspErr_q   <= 1'b0;
            end else if (accept) begin
                rspValid_q <= 1'b1;
                rspRdata_q <= rdNext;
                rspErr_q   <= addrErr;
            end else if (rsp_ready) begin
                rspValid_q <= 1'b0;
            end
        end

        assign cmd_ready = (state_q == RUN) & outAdv;
    end else begin : gOutReg
        logic          s1Valid_q;
        logic [DW-1:0] s1Rdata_q;
        logic          s1Err_q;

        // Stage1 refills on the same edge it drains into the output register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1Valid_q  <= 1'b0;
                s1Rdata_q  <= '0;
                s1Err_q    <= 1'b0;
                rspValid_q <= 1'b0;
                rspRdata_q <= '0;
                rspErr_q   <= 1'b0;
            end else begin
                if (accept) begin
                    s1Valid_q <= 1'b1;
                    s1Rdata_q <= rdNext;
                    s1Err_q   <= addrErr;
                end else if (outAdv) begin
                    s1Valid_q <= 1'b0;
                end
                if (outAdv) begin
                    rspValid_q <= s1Valid_q;
                    rspRdata_q <= s1Rdata_q;
                    rspErr_q   <= s1Err_q;
                end
            end
        end

        assign cmd_ready = (state_q == RUN) & ~(s1Valid_q & rspValid_q & ~rsp_ready);
    end

    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
    assign init_done = initDone_q;

endmodule

// File: tb/tb_sirv_tcm_ram_bank.sv
// Bench for sirv_tcm_ram_bank: a 16-word OUT_REG=0 bank and a 512-word OUT_REG=1 bank
// driven from one vector table, with hand-written reset, burst and backpressure sequences.
module tb_sirv_tcm_ram_bank;

    localparam int DP0 = 16;
    localparam int DP1 = 512;
    localparam int AW  = 10;
`ifdef SIRV_TCM_INIT_CLEAR_EN
    localparam int INIT_LAT0 = DP0 + 1;
    localparam int INIT_LAT1 = DP1 + 1;
`else
    localparam int INIT_LAT0 = 1;
    localparam int INIT_LAT1 = 1;
`endif

    typedef struct {
        logic          read;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic [31:0]   expData;
        logic          expErr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acceptEdge;
        bit          chkLat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]          cmdValid, cmdReady, cmdRead, rspValid, rspReady, rspErr, initDone;
    logic [1:0][AW-1:0]  cmdAddr;
    logic [1:0][31:0]    cmdWdata, rspRdata;
    logic [1:0][3:0]     cmdWmask;

    exp_t expQ0[$];
    exp_t expQ1[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sirv_tcm_ram_bank #(.DP(DP0), .AW(AW), .DW(32), .MW(4), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmdValid[0]), .cmd_ready(cmdReady[0]), .cmd_read(cmdRead[0]),
        .cmd_addr(cmdAddr[0]), .cmd_wdata(cmdWdata[0]), .cmd_wmask(cmdWmask[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]),
        .rsp_err(rspErr[0]), .init_done(initDone[0])
    );

    sirv_tcm_ram_bank #(.DP(DP1), .AW(AW), .DW(32), .MW(4), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmdValid[1]), .cmd_ready(cmdReady[1]), .cmd_read(cmdRead[1]),
        .cmd_addr(cmdAddr[1]), .cmd_wdata(cmdWdata[1]), .cmd_wmask(cmdWmask[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]),
        .rsp_err(rspErr[1]), .init_done(initDone[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int d, input logic [31:0] data, input logic err, input bit chkLat);
        exp_t e;
        e.data       = data;
        e.err        = err;
        e.acceptEdge = cyc + 1;
        e.chkLat     = chkLat;
        if (d == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    // Every handshaken response is matched in order against what was accepted.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && rspValid[d] && rspReady[d]) begin
                if ((d == 0 && expQ0.size() == 0) || (d == 1 && expQ1.size() == 0)) begin
                    checkOutput($sformatf("unexpected_rsp%0d", d), 32'd1, 32'd0);
                end else begin
                    if (d == 0) e = expQ0.pop_front();
                    else        e = expQ1.pop_front();
                    checkOutput($sformatf("rsp_rdata%0d", d), rspRdata[d], e.data);
                    checkOutput($sformatf("rsp_err%0d", d), {31'b0, rspErr[d]}, {31'b0, e.err});
                    if (e.chkLat)
                        checkOutput($sformatf("rsp_latency%0d", d), 32'(cyc - e.acceptEdge + 1), 32'(d + 1));
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input vec_t v, input bit chkLat);
        int waitCnt = 0;
        cmdValid[d] = 1'b1;
        cmdRead[d]  = v.read;
        cmdAddr[d]  = v.addr;
        cmdWdata[d] = v.wdata;
        cmdWmask[d] = v.wmask;
        @(negedge clk);
        while (!cmdReady[d] && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (cmdReady[d]) pushExp(d, v.expData, v.expErr, chkLat);
        else checkOutput($sformatf("cmd_timeout%0d", d), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmdValid[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (expQ0.size() + expQ1.size()) > 0; i++) @(negedge clk);
        checkOutput("drain_empty", 32'(expQ0.size() + expQ1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string name);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_flags%0d", name, d),
                        {28'b0, cmdReady[d], rspValid[d], rspErr[d], initDone[d]}, 32'd0);
            checkOutput($sformatf("%s_rdata%0d", name, d), rspRdata[d], 32'd0);
        end
    endtask

    task automatic measureInit();
        int lat0 = -1;
        int lat1 = -1;
        for (int k = 1; k <= 2000 && (lat0 < 0 || lat1 < 0); k++) begin
            @(negedge clk);
            if (lat0 < 0 && initDone[0]) lat0 = k;
            if (lat1 < 0 && initDone[1]) lat1 = k;
        end
        checkOutput("init_latency0", 32'(lat0), 32'(INIT_LAT0));
        checkOutput("init_latency1", 32'(lat1), 32'(INIT_LAT1));
    endtask

    // Fills the pipeline under rsp_ready=0, then releases it with a command still pending.
    task automatic bpTest(input int d);
        logic [AW-1:0] addrs [4];
        logic [31:0]   datas [4];
        int            idx = 0;
        addrs[0] = 10'd3; datas[0] = 32'hA522A544;
        addrs[1] = 10'd8; datas[1] = 32'hCAFEF00D;
        addrs[2] = 10'd5; datas[2] = 32'hDEADBEEF;
        addrs[3] = 10'd7; datas[3] = 32'hFF00FF00;
        rspReady[d] = 1'b0;
        cmdValid[d] = 1'b1;
        cmdRead[d]  = 1'b1;
        cmdAddr[d]  = addrs[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= d + 1) begin
                checkOutput($sformatf("bp_hold_valid%0d", d), {31'b0, rspValid[d]}, 32'd1);
                checkOutput($sformatf("bp_hold_rdata%0d", d), rspRdata[d], datas[0]);
            end
            if (cmdReady[d]) begin
                pushExp(d, datas[idx % 4], 1'b0, 1'b0);
                idx++;
            end
            @(posedge clk);
            #1;
            cmdAddr[d] = addrs[idx % 4];
        end
        @(negedge clk);
        checkOutput($sformatf("bp_full_ready%0d", d), {31'b0, cmdReady[d]}, 32'd0);
        checkOutput($sformatf("bp_accepted%0d", d), 32'(idx), 32'(d + 1));
        @(posedge clk);
        #1;
        rspReady[d] = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("bp_pop_accept%0d", d), {31'b0, cmdReady[d]}, 32'd1);
        if (cmdReady[d]) pushExp(d, datas[idx % 4], 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cmdValid[d] = 1'b0;
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        vec_t        tbl [17];
        logic [AW-1:0] burstAddr [8];
        logic [31:0]   burstData [8];

        tbl[0]  = '{1'b0, 10'd3,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 10'd3,   32'h11223344, 4'h5, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 10'd3,   32'h0,        4'h0, 32'hA522A544, 1'b0};
        tbl[3]  = '{1'b0, 10'd8,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 10'd520, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 10'd600, 32'h12345678, 4'hF, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 10'd8,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[7]  = '{1'b1, 10'd600, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 10'd5,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 10'd5,   32'h00000000, 4'h0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 10'd5,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[11] = '{1'b0, 10'd7,   32'h00000000, 4'hF, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 10'd7,   32'hFFFFFFFF, 4'hA, 32'h0,        1'b0};
        tbl[13] = '{1'b1, 10'd7,   32'h0,        4'h0, 32'hFF00FF00, 1'b0};
        tbl[14] = '{1'b1, 10'd520, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[15] = '{1'b1, 10'd3,   32'h0,        4'h0, 32'hA522A544, 1'b0};
        tbl[16] = '{1'b1, 10'd600, 32'h0,        4'h0, 32'h0,        1'b1};

        for (int i = 0; i < 8; i++) begin
            burstAddr[i] = (i % 4 == 0) ? 10'd3 : (i % 4 == 1) ? 10'd8 : (i % 4 == 2) ? 10'd5 : 10'd7;
            burstData[i] = (i % 4 == 0) ? 32'hA522A544 : (i % 4 == 1) ? 32'hCAFEF00D :
                           (i % 4 == 2) ? 32'hDEADBEEF : 32'hFF00FF00;
        end

        cmdValid = '0;
        cmdRead  = '0;
        cmdAddr  = '0;
        cmdWdata = '0;
        cmdWmask = '0;
        rspReady = 2'b11;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("mid_reset");
        expQ0.delete();
        expQ1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        measureInit();
        @(posedge clk);
        #1;

`ifdef SIRV_TCM_INIT_CLEAR_EN
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < DP0; a++)
                applyStimulus(d, '{1'b1, AW'(a), 32'h0, 4'h0, 32'h0, 1'b0}, 1'b1);
        drain();
`endif

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 17; i++)
                applyStimulus(d, tbl[i], 1'b1);
        drain();

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++)
                applyStimulus(d, '{1'b1, burstAddr[i], 32'h0, 4'h0, burstData[i], 1'b0}, 1'b1);
            drain();
        end

        bpTest(0);
        bpTest(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
